// File: rtl/xbar_rr_router.sv
// xbar_rr_router: registered IN_CH x OUT_CH tile crossbar; conflicting inputs are serialised
// per output by round-robin. Define XBAR_REDUCE_EN to sum conflicting tiles in one beat instead.
module xbar_rr_router #(
    parameter int IN_CH  = 8,
    parameter int OUT_CH = 8,
    parameter int HEIGHT = 4,
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16,
    localparam int DST_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int TILE_W = HEIGHT * WIDTH * DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_CH-1:0]          is_index,
    input  logic [IN_CH*DST_W-1:0]    dest,
    input  logic [IN_CH*TILE_W-1:0]   in_tile,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_CH*TILE_W-1:0]  out_tile,
    output logic [OUT_CH-1:0]         channel_en,
    output logic                      last,
    output logic                      state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and held outputs stay stable while valid && !ready.
    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;
    state_t state, state_nx;

    logic [IN_CH-1:0]         pend_q, pend_clr, dest_ok;
    logic [IN_CH*DST_W-1:0]   dest_q;
    logic [IN_CH*TILE_W-1:0]  tile_q;
    logic [OUT_CH-1:0]        gnt_en;
    logic [OUT_CH*TILE_W-1:0] beat_tile;
    logic                     advance, pend_empty_nx;

    assign in_ready      = (state == IDLE);
    assign state_dbg     = state;
    assign advance       = !out_valid || out_ready;
    assign pend_empty_nx = ((pend_q & ~pend_clr) == '0);

    // Inputs whose dest falls outside the output range are dropped at acceptance.
    always_comb begin
        for (int i = 0; i < IN_CH; i++) begin
            dest_ok[i] = (int'(dest[i*DST_W +: DST_W]) < OUT_CH);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = DRAIN;
            DRAIN:   if (advance && out_valid && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef XBAR_REDUCE_EN
    logic [DATA_W-1:0] acc;

    always_comb begin
        gnt_en    = '0;
        pend_clr  = pend_q;
        beat_tile = out_tile;
        acc       = '0;
        for (int j = 0; j < OUT_CH; j++) begin
            for (int e = 0; e < HEIGHT*WIDTH; e++) begin
                acc = '0;
                for (int i = 0; i < IN_CH; i++) begin
                    if (pend_q[i] && dest_q[i*DST_W +: DST_W] == DST_W'(j)) begin
                        acc       = acc + tile_q[i*TILE_W + e*DATA_W +: DATA_W];
                        gnt_en[j] = 1'b1;
                    end
                end
                if (gnt_en[j]) beat_tile[j*TILE_W + e*DATA_W +: DATA_W] = acc;
            end
        end
    end
`else
    localparam int PTR_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    logic [PTR_W-1:0] rr_ptr  [OUT_CH];
    logic [PTR_W-1:0] gnt_idx [OUT_CH];
    int               cand;

    // Per output: first pending candidate in circular order starting at rr_ptr.
    always_comb begin
        gnt_en    = '0;
        pend_clr  = '0;
        beat_tile = out_tile;
        cand      = 0;
        for (int j = 0; j < OUT_CH; j++) begin
            gnt_idx[j] = '0;
            for (int k = 0; k < IN_CH; k++) begin
                cand = int'(rr_ptr[j]) + k;
                if (cand >= IN_CH) cand = cand - IN_CH;
                if (!gnt_en[j] && pend_q[cand] && dest_q[cand*DST_W +: DST_W] == DST_W'(j)) begin
                    gnt_en[j]      = 1'b1;
                    gnt_idx[j]     = PTR_W'(cand);
                    pend_clr[cand] = 1'b1;
                end
            end
            if (gnt_en[j]) beat_tile[j*TILE_W +: TILE_W] = tile_q[int'(gnt_idx[j])*TILE_W +: TILE_W];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < OUT_CH; j++) rr_ptr[j] <= '0;
        end else if (state == DRAIN && advance && !(out_valid && last)) begin
            for (int j = 0; j < OUT_CH; j++) begin
                if (gnt_en[j])
                    rr_ptr[j] <= (gnt_idx[j] == PTR_W'(IN_CH-1)) ? '0 : gnt_idx[j] + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            dest_q     <= '0;
            tile_q     <= '0;
            out_valid  <= 1'b0;
            out_tile   <= '0;
            channel_en <= '0;
            last       <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                pend_q <= is_index & dest_ok;
                dest_q <= dest;
                tile_q <= in_tile;
            end
        end else if (advance) begin
            if (out_valid && last) begin
                out_valid  <= 1'b0;
                last       <= 1'b0;
                channel_en <= '0;
            end else begin
                out_valid  <= 1'b1;
                out_tile   <= beat_tile;
                channel_en <= gnt_en;
                last       <= pend_empty_nx;
                pend_q     <= pend_q & ~pend_clr;
            end
        end
    end
endmodule

// File: doc/xbar_rr_router.md
Name: xbar_rr_router

Overview:
- Registered, parametrised successor to the MPE-to-APE crossbar.
- Routes each flagged input channel's HxW output tile to its target output channel, i.e. MPE outputs to APE inputs.
- Conflicts (several input channels targeting one output channel) are never driven onto the output together. A per-output round-robin arbiter serialises them over successive cycles.
- Valid/ready handshakes on both sides.

Parameters:
- IN_CH, 8, number of input (MPE) channels
- OUT_CH, 8, number of output (APE) channels
- HEIGHT, 4, tile rows
- WIDTH, 4, tile columns
- DATA_W, 16, bits per tile element (two's complement)
- Derived: DST_W = $clog2(OUT_CH), TILE_W = HEIGHT*WIDTH*DATA_W

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  batch presented
- in_ready  out  1  router can accept a batch
- is_index  in  IN_CH  bit i: input channel i carries data this batch
- dest  in  IN_CH*DST_W  target output channel of input i (slice i)
- in_tile  in  IN_CH*TILE_W  tile of input i, element [r][c] at offset ((r*WIDTH+c)*DATA_W)
- out_valid  out  1  output register holds a valid beat
- out_ready  in  1  downstream accepts the beat
- out_tile  out  OUT_CH*TILE_W  routed tile per output channel
- channel_en  out  OUT_CH  bit j: out_tile slice j valid this beat
- last  out  1  beat is final beat of the batch

Behaviour:
- Reset (asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, channel_en=0, last=0, out_tile=0.
  - Pending mask cleared; all rr_ptr[j]=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch is_index, dest, in_tile; pending = is_index; go to DRAIN.
  - A batch with is_index=0 is accepted and produces one beat next cycle: channel_en=0, last=1, out_valid=1.
- DRAIN:
  - in_ready=0.
  - Advance condition: !out_valid || out_ready.
  - Each advancing cycle, for every output j, grant the pending input i with dest[i]==j that is first in circular order starting at rr_ptr[j].
  - Register the granted tile into out_tile slice j; set channel_en[j]=1.
  - Clear pending[i]; rr_ptr[j] = (i+1) mod IN_CH.
  - Outputs with no candidate get channel_en[j]=0 and a held slice value.
  - last=1 on the beat that empties pending; next state IDLE once that beat is accepted.
- Stall: out_valid&&!out_ready holds out_tile, channel_en, last, pending and rr_ptr unchanged.
- Latency:
  - First beat is registered one cycle after acceptance.
  - Batch occupies max over j of (count of pending inputs targeting j) beats; minimum 1.
- Back-to-back: in_ready rises the cycle after the last beat's handshake. No overlap between batches.
- dest >= OUT_CH (non-power-of-2 OUT_CH): the input is dropped (pending cleared at acceptance) and never appears on any channel.
- rr_ptr persists across batches for fairness.
- Reset mid-DRAIN aborts the batch immediately; no further beats are emitted.

Optional Feature:
- Macro XBAR_REDUCE_EN.
- Defined: all pending inputs targeting output j are summed element-wise in one beat (adder tree, modulo 2^DATA_W wrap). Every batch drains in exactly 1 beat with last=1; rr_ptr is unused and stays 0.
- Undefined: round-robin serialisation as above; no adders synthesised.

Test Plan:
All cases use IN_CH=4, OUT_CH=4, H=W=2, DATA_W=16, out_ready=1 unless noted.
- No conflict: is_index=4'b1111, dest={3,2,1,0}, tiles all 0x0011*(i+1) -> one beat, channel_en=4'b1111, slice j = 0x0011*(j+1), last=1, in_ready back next cycle.
- Full conflict: all four inputs target 2 -> four beats, channel_en=4'b0100 each, order i=0,1,2,3, last only on beat 4. A second identical batch starts at i=0 (rr_ptr wrapped to 0).
- Fairness: batch 1 has inputs 0,1 to output 0 -> order 0,1. Batch 2 has inputs 1,2 to output 0 with rr_ptr=2 -> order 2,1.
- Stall: full-conflict batch with out_ready low for 3 cycles on beat 2 -> beat 2 held stable 3 cycles, no beat skipped, total 4 distinct beats.
- Empty/reset: is_index=0 -> single beat, channel_en=0, last=1. Reset asserted mid-DRAIN -> out_valid=0 and in_ready=1 asynchronously; next batch routes correctly.
- XBAR_REDUCE_EN: inputs 0..3 all target output 1 with every element 0x4000 -> one beat, slice 1 elements = 0x0000 (wrap), channel_en=4'b0010, last=1.
